memory_arbiter: RTL



---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/arb_starve_cnt.sv | 31 +++
 rtl/memory_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU word, RAM-status and arbiter-state types.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arbstate_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_cnt
// Purpose  : Saturating count of data grants served while a fetch waits.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);
    localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_at_limit = (r_cnt >= c_limit);

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Fixed-priority (data over fetch) arbiter onto one RAM port.
//            Define ARB_STARVE_GUARD_EN to bound fetch starvation.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      ihit,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);
    arbstate_t r_state;
    logic      w_dreq;
    logic      w_starve;

    assign w_dreq = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_starve && iREN) r_state <= IGNT;
                    else if (w_dreq)      r_state <= DGNT;
                    else if (iREN)        r_state <= IGNT;
                    else                  r_state <= IDLE;
                end
                // A dropped request or a completed access both return to IDLE.
                IGNT: if (!iREN || ramstate == ACCESS) r_state <= IDLE;
                DGNT: if (!w_dreq || ramstate == ACCESS) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM side follows the granted requester; hits are combinational.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        if (!RST) begin
            case (r_state)
                IGNT: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (iREN && ramstate == ACCESS) begin
                        ihit  = 1'b1;
                        iload = ramload;
                    end
                end
                DGNT: begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (w_dreq && ramstate == ACCESS) begin
                        dhit  = 1'b1;
                        dload = ramload;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_cnt_inc = dhit & iREN;
    assign w_cnt_clr = ihit | ((r_state == IDLE) & ~iREN);

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (CLK),
        .rst        (RST),
        .i_inc      (w_cnt_inc),
        .i_clr      (w_cnt_clr),
        .o_at_limit (w_starve)
    );
`else
    assign w_starve = 1'b0;
`endif

endmodule
`default_nettype wire
